// File: rtl/lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lite_pkg
// Description : Shared types for the lite_v2 execution unit: opcode
//               encoding, opcode width and the control-state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lite_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        PASS_A = 3'd0,
        PASS_B = 3'd1,
        ADD    = 3'd2,
        SUB    = 3'd3,
        AND    = 3'd4,
        OR     = 3'd5,
        XOR    = 3'd6,
        MUL    = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/lite_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : lite_mul_seq
// Description : Unsigned shift-add multiplier, one partial product per clock.
//               start loads the operands; done is high during the cycle whose
//               closing edge performs the last iteration, and product then
//               shows the final value (so the caller can register it on that
//               same edge).
// Revision    : 1.0 - initial release
// ============================================================================
module lite_mul_seq #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_run;
    logic [2*DATA_W-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign done       = r_run && (r_cnt == C_LAST);
    assign product    = w_acc_next;

    // Operand load on start, then one shift-add step per clock for DATA_W clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
        end else if (start) begin
            r_acc    <= '0;
            r_mcand  <= {{DATA_W{1'b0}}, a};
            r_mplier <= b;
            r_cnt    <= '0;
            r_run    <= 1'b1;
        end else if (r_run) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (r_cnt == C_LAST) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lite_v2.sv
`default_nettype none
// ============================================================================
// Module      : lite_v2
// Description : Registered execution unit with valid/ready handshakes.
//               Single-cycle pass/add/sub/logic ops, multi-cycle sequential
//               multiply; reports carry, zero and truncation flags.
// Revision    : 1.0 - initial release
// ============================================================================
module lite_v2
    import lite_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int B_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] d1,
    input  logic [B_W-1:0]    d2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] res,
    output logic              carry,
    output logic              zero,
    output logic              trunc,
    output logic              busy
);

    state_e              r_state;
    state_e              w_state_nx;
    op_e                 w_op;
    logic [DATA_W-1:0]   w_b;
    logic                w_tb;
    logic                w_accept;
    logic                w_ready_st;
    logic                w_mul_start;
    logic                w_mul_done;
    logic [2*DATA_W-1:0] w_product;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_alu_carry;
    logic                w_alu_trunc;
    logic [DATA_W-1:0]   r_res;
    logic                r_carry;
    logic                r_zero;
    logic                r_trunc;
    logic                r_mul_tb;

    assign w_op = op_e'(opcode);
    assign w_b  = d2[DATA_W-1:0];

    // Upper d2 bits only exist when B_W is wider than the datapath.
    generate
        if (B_W > DATA_W) begin : g_trunc_src
            assign w_tb = |d2[B_W-1:DATA_W];
        end else begin : g_no_trunc_src
            assign w_tb = 1'b0;
        end
    endgenerate

    // in_ready is held low while reset is asserted, independent of state.
    assign in_ready    = rst && w_ready_st;
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (w_op == MUL);
    assign out_valid   = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign res         = r_res;
    assign carry       = r_carry;
    assign zero        = r_zero;
    assign trunc       = r_trunc;

    lite_mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (d1),
        .b       (w_b),
        .done    (w_mul_done),
        .product (w_product)
    );

    // Single-cycle result and flags for opcodes 0-6.
    always_comb begin
        w_sum       = '0;
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        w_alu_trunc = w_tb;
        case (w_op)
            PASS_A: begin
                w_alu_res   = d1;
                w_alu_trunc = 1'b0;
            end
            PASS_B: w_alu_res = w_b;
            ADD: begin
                w_sum       = {1'b0, d1} + {1'b0, w_b};
                w_alu_res   = w_sum[DATA_W-1:0];
                w_alu_carry = w_sum[DATA_W];
            end
            SUB: begin
                w_alu_res   = d1 - w_b;
                w_alu_carry = (d1 < w_b);
            end
            AND:     w_alu_res = d1 & w_b;
            OR:      w_alu_res = d1 | w_b;
            XOR:     w_alu_res = d1 ^ w_b;
            default: w_alu_res = '0;
        endcase
    end

    // Next-state and in_ready; a handshake in DONE may take a new request.
    always_comb begin
        w_state_nx = r_state;
        w_ready_st = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready_st = 1'b1;
                if (w_accept) begin
                    w_state_nx = (w_op == MUL) ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (w_mul_done) begin
                    w_state_nx = DONE;
                end
            end
            DONE: begin
                w_ready_st = out_ready;
                if (out_ready) begin
                    if (w_accept) begin
                        w_state_nx = (w_op == MUL) ? EXEC : DONE;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Result/flag registers: load on single-cycle accept or multiply completion,
    // otherwise hold. The d2 truncation bit of a MUL is kept until it finishes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res    <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_trunc  <= 1'b0;
            r_mul_tb <= 1'b0;
        end else if (w_mul_start) begin
            r_mul_tb <= w_tb;
        end else if (w_accept) begin
            r_res   <= w_alu_res;
            r_carry <= w_alu_carry;
            r_zero  <= (w_alu_res == '0);
            r_trunc <= w_alu_trunc;
        end else if ((r_state == EXEC) && w_mul_done) begin
            r_res   <= w_product[DATA_W-1:0];
            r_carry <= 1'b0;
            r_zero  <= (w_product[DATA_W-1:0] == '0);
            r_trunc <= r_mul_tb | (|w_product[2*DATA_W-1:DATA_W]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lite_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_lite_v2
// Description : Self-checking bench for lite_v2 (DATA_W=8, B_W=10) with a
//               queue scoreboard filled at accept and drained at handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lite_v2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] opcode;
    logic [7:0] d1;
    logic [9:0] d2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] res;
    logic       carry;
    logic       zero;
    logic       trunc;
    logic       busy;

    typedef struct packed {
        logic [7:0] res;
        logic       carry;
        logic       zero;
        logic       trunc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lite_v2 #(.DATA_W(8), .B_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .d1        (d1),
        .d2        (d2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .carry     (carry),
        .zero      (zero),
        .trunc     (trunc),
        .busy      (busy)
    );

    // Reference model of one operation.
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [9:0] d);
        exp_t        e;
        logic [7:0]  b;
        logic        tb;
        logic [15:0] p;
        logic [8:0]  s;
        b  = d[7:0];
        tb = (d[9:8] != 2'b00);
        e  = '0;
        e.trunc = tb;
        case (op)
            3'd0: begin e.res = a; e.trunc = 1'b0; end
            3'd1: e.res = b;
            3'd2: begin s = 9'(a) + 9'(b); e.res = s[7:0]; e.carry = s[8]; end
            3'd3: begin e.res = a - b; e.carry = (a < b); end
            3'd4: e.res = a & b;
            3'd5: e.res = a | b;
            3'd6: e.res = a ^ b;
            default: begin p = 16'(a) * 16'(b); e.res = p[7:0]; e.trunc = tb | (p[15:8] != 8'h00); end
        endcase
        e.zero = (e.res == 8'h00);
        return e;
    endfunction

    // Drive one request (from posedge+1) until accepted; push its expectation.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [9:0] b);
        bit rdy;
        bit ok = 1'b0;
        in_valid = 1'b1; opcode = op; d1 = a; d2 = b;
        for (int k = 0; k < 60 && !ok; k++) begin
            #1; rdy = in_ready;
            @(posedge clk);
            if (rdy) begin sb.push_back(model(op, a, b)); ok = 1'b1; end
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout op=%0d got no accept, required accept within 60 cycles", op);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opcode = '0; d1 = '0; d2 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready, busy, res, carry, zero, trunc} !== 14'h0) begin
            errors++;
            $display("FAIL reset_state got ov=%b ir=%b busy=%b res=%h c=%b z=%b t=%b, required all 0",
                     out_valid, in_ready, busy, res, carry, zero, trunc);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b required 1", in_ready); end
        send(3'd0, 8'h5A, 10'h000);
        checks++;
        if (out_valid !== 1'b1 || res !== 8'h5A) begin
            errors++; $display("FAIL pre_abort_valid got ov=%b res=%h required ov=1 res=5a", out_valid, res);
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, busy, res, carry, zero, trunc} !== 14'h0) begin
            errors++;
            $display("FAIL async_reset got ov=%b ir=%b busy=%b res=%h c=%b z=%b t=%b, required all 0",
                     out_valid, in_ready, busy, res, carry, zero, trunc);
        end
        sb.delete();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release got ir=%b ov=%b required ir=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_pass_b();
        exp_t e;
        send(3'd1, 8'h00, 10'h3A5);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pass_b_latency got ov=%b required 1", out_valid); end
        e = sb.pop_front();
        checks++;
        if ({res, carry, zero, trunc} !== e || e !== {8'hA5, 3'b001}) begin
            errors++; $display("FAIL pass_b got %h required %h", {res, carry, zero, trunc}, {8'hA5, 3'b001});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || res !== 8'hA5 || trunc !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL pass_b_retain got ov=%b res=%h t=%b ir=%b required ov=0 res=a5 t=1 ir=1",
                               out_valid, res, trunc, in_ready);
        end
    endtask

    task automatic test_add_sub();
        logic [2:0]  ops [3] = '{3'd2, 3'd3, 3'd3};
        logic [7:0]  as  [3] = '{8'hF0, 8'h05, 8'h03};
        logic [9:0]  bs  [3] = '{10'h020, 10'h005, 10'h005};
        logic [10:0] req [3] = '{{8'h10, 3'b100}, {8'h00, 3'b010}, {8'hFE, 3'b100}};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            send(ops[i], as[i], bs[i]);
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {res, carry, zero, trunc} !== e || e !== req[i]) begin
                errors++; $display("FAIL add_sub[%0d] got ov=%b %h required ov=1 %h",
                                   i, out_valid, {res, carry, zero, trunc}, req[i]);
            end
            out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        end
    endtask

    task automatic test_mul();
        exp_t e;
        bit   seen;
        send(3'd7, 8'h0F, 10'h011);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mul_exec_entry got busy=%b ir=%b ov=%b required 1 0 0", busy, in_ready, out_valid);
        end
        in_valid = 1'b1; opcode = 3'd0; d1 = 8'h77; d2 = 10'h0;
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++; $display("FAIL mul_exec[%0d] got ov=%b ir=%b required 0 0", k, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {res, carry, zero, trunc} !== e || e !== {8'hFF, 3'b000} || sb.size() != 0) begin
            errors++; $display("FAIL mul_0f_11 got ov=%b %h required ov=1 %h", out_valid, {res, carry, zero, trunc},
                               {8'hFF, 3'b000});
        end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        send(3'd7, 8'h10, 10'h010);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        e = sb.pop_front();
        checks++;
        if (!seen || {res, carry, zero, trunc} !== e || e !== {8'h00, 3'b011}) begin
            errors++; $display("FAIL mul_10_10 got ov=%b %h required ov=1 %h", out_valid, {res, carry, zero, trunc},
                               {8'h00, 3'b011});
        end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [10:0] snap;
        exp_t        e;
        bit          seen;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(3'd6, 8'(i * 37 + 5), 10'(i * 91));
                end
            end
            begin
                out_ready = 1'b0;
                seen = 1'b0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    if (out_valid === 1'b1) seen = 1'b1;
                    else begin @(posedge clk); #1; end
                end
                snap = {res, carry, zero, trunc};
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (!seen || out_valid !== 1'b1 || {res, carry, zero, trunc} !== snap || sb.size() != 1) begin
                        errors++; $display("FAIL hold[%0d] got ov=%b %h queued=%0d required ov=1 %h queued=1",
                                           k, out_valid, {res, carry, zero, trunc}, sb.size(), snap);
                    end
                end
                out_ready = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    e = (sb.size() > 0) ? sb.pop_front() : exp_t'('x);
                    checks++;
                    if (out_valid !== 1'b1 || {res, carry, zero, trunc} !== e) begin
                        errors++; $display("FAIL b2b[%0d] got ov=%b %h required ov=1 %h",
                                           i, out_valid, {res, carry, zero, trunc}, e);
                    end
                    @(posedge clk); #1;
                end
                out_ready = 1'b0;
            end
        join
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL b2b_drain got ov=%b queued=%0d required ov=0 queued=0", out_valid, sb.size());
        end
    endtask

    task automatic test_abort();
        exp_t e;
        bit   stray;
        send(3'd7, 8'h0F, 10'h003);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL abort_reset got busy=%b ov=%b ir=%b required 0 0 0", busy, out_valid, in_ready);
        end
        sb.delete();
        @(negedge clk) rst = 1'b1;
        stray = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin errors++; $display("FAIL abort_no_result got out_valid=1 required 0"); end
        send(3'd2, 8'h01, 10'h001);
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {res, carry, zero, trunc} !== e || e !== {8'h02, 3'b000}) begin
            errors++; $display("FAIL add_after_abort got ov=%b %h required ov=1 %h", out_valid,
                               {res, carry, zero, trunc}, {8'h02, 3'b000});
        end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pass_b();
        test_add_sub();
        test_mul();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
